motor_run_sequencer: RTL and testbench
======================================

# motor_run_sequencer

Sequencing controller for the rotating-mirror motor drive. It takes host-level start, stop, calibrate and speed-select requests and produces the drive's measure-mode, cal-mode and frequency-mode controls. It waits for the drive's speed-lock flag, enforces a spin-up timeout with a bounded automatic restart, and handles drop-out of lock during a run. It publishes a single `o_scan_ready` qualifier for the ranging datapath.

## Interface
Parameters:
- `SPINUP_TIMEOUT`, default 32'd1_500_000_000: cycles allowed from spin-up entry to lock (30 s at 50 MHz).
- `RESTART_GAP`, default 32'd50_000_000: cycles the drive is held off between restart attempts, and on a speed change (1 s).
- `LOSS_FILTER`, default 24'd5_000_000: consecutive cycles with lock low in RUN before lock loss is declared (100 ms).
- `MAX_RETRY`, default 3'd3: restart attempts before FAULT.

Ports:
- `i_clk_50m` in 1: system clock, 50 MHz.
- `i_rst_n` in 1: reset. Synchronous, active-low.
- `i_start_req` in 1: one-cycle pulse; start scanning.
- `i_stop_req` in 1: one-cycle pulse; stop the motor.
- `i_cal_req` in 1: level; calibration mode requested.
- `i_freq_req` in 3: requested speed code (0=15, 1=20, 2=25, 3=30, 4=33, 5=40, 6=50 Hz).
- `i_motor_state` in 1: speed-locked flag from the motor drive.
- `o_freq_mode` out 3: speed code driven to the motor drive.
- `o_measure_mode` out 1: motor enable to the drive.
- `o_cal_mode` out 1: calibration mode to the drive.
- `o_scan_ready` out 1: motor locked; ranging may run.
- `o_fault` out 1: sticky fault; cleared only by a start request or reset.
- `o_retry_cnt` out 3: restart attempts used in the current start.
- `o_state` out 3: state code, for debug registers.

## Operation
States and `o_state` codes: IDLE=0, SPINUP=1, RUN=2, GAP=3, CAL=4, FAULT=5.

Rules that apply to every state:
- All outputs are registered.
- A 32-bit cycle counter is cleared on every state entry.
- `i_freq_req` is sampled into `o_freq_mode` only on entry to SPINUP. The value 7 is mapped to 0.

Request priority, evaluated in every state each cycle:
1. `i_stop_req`
2. `i_cal_req`
3. `i_start_req`
4. Internal events

State behaviour:
- **IDLE**
  - Drives measure=0, cal=0, ready=0.
  - `i_start_req` → SPINUP. Clears `o_fault` and `o_retry_cnt`.
  - `i_cal_req` high → CAL.
- **SPINUP**
  - Drives measure=1.
  - `i_motor_state` high → RUN.
  - Counter reaching `SPINUP_TIMEOUT`-1 → GAP if `o_retry_cnt < MAX_RETRY` (`o_retry_cnt` increments), otherwise → FAULT.
- **RUN**
  - Drives measure=1; `o_scan_ready` = 1.
  - Lock-loss counter clears whenever `i_motor_state`=1. When it reaches `LOSS_FILTER`, go → GAP; `o_retry_cnt` increments, saturating at `MAX_RETRY`.
  - `i_freq_req` ≠ `o_freq_mode` for 1 cycle → GAP, with no retry increment.
- **GAP**
  - Drives measure=0.
  - After `RESTART_GAP` cycles → SPINUP.
  - If entered from lock loss with `o_retry_cnt` already equal to `MAX_RETRY` → FAULT.
- **CAL**
  - Drives measure=1, cal=1, ready=0.
  - `i_cal_req` low → IDLE.
- **FAULT**
  - Drives measure=0 and `o_fault`=1.
  - Only `i_start_req` (→ SPINUP, clears fault and retries) or `i_cal_req` (→ CAL, fault stays set) leaves this state.
- **Stop:** `i_stop_req` in any state → IDLE next cycle, outputs low. `o_fault` is held.

## Timing
- Reset values: `o_freq_mode`=0, `o_measure_mode`=0, `o_cal_mode`=0, `o_scan_ready`=0, `o_fault`=0, `o_retry_cnt`=0, `o_state`=0.
- Reset asserted mid-operation returns to IDLE on the next edge; reset dominates all requests.
- Request to output change: 1 cycle. A pulse at edge N gives new outputs at edge N+1.
- `o_scan_ready` rises in the cycle after `i_motor_state` is sampled high in SPINUP. It falls in the same cycle the state leaves RUN.
- Timeout: SPINUP lasts exactly `SPINUP_TIMEOUT` cycles without lock.
- GAP lasts exactly `RESTART_GAP` cycles.
- Simultaneous events resolve by the priority list; a stop in the same cycle as lock wins.
- `i_start_req` in SPINUP or RUN is ignored.
- Counters saturate and never wrap.

## Configuration
- `MOTOR_AUTO_RETRY_EN` defined: retry and restart behaviour as described above.
- Not defined: `MAX_RETRY` is treated as 0.
  - Timeout or lock loss → FAULT directly.
  - GAP is used only for speed changes.
  - `o_retry_cnt` is held at 0.

## Test plan
- **Lock:** `SPINUP_TIMEOUT`=1000; start, `i_motor_state`↑ at cycle 200 → `o_scan_ready`=1 at cycle 201, `o_state`=2.
- **Timeout retry:** `MAX_RETRY`=2, lock never arrives.
  - 3 SPINUP windows of 1000 cycles, separated by GAPs of `RESTART_GAP` cycles.
  - Then `o_fault`=1, `o_retry_cnt`=2, `o_measure_mode`=0.
- **Lock loss:** in RUN with `LOSS_FILTER`=50.
  - `i_motor_state` low for 49 cycles → stay in RUN.
  - Low for 50 cycles → GAP, `o_scan_ready`=0, `o_retry_cnt`=1.
- **Speed change:** in RUN, `i_freq_req` 0→3.
  - GAP with measure=0 for the full gap, then SPINUP with `o_freq_mode`=3 and `o_retry_cnt` unchanged.
- **Priority:** stop, cal and start asserted together in RUN → IDLE, all outputs 0.
  - Reset pulsed during GAP → all outputs take their reset values.
- **Macro off:** first timeout → FAULT with no GAP; `o_retry_cnt`=0.

Source files
------------

// File: rtl/motor_run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : motor_run_sequencer
//  Purpose  : Start/stop/calibrate sequencer for the rotating-mirror motor
//             drive. Waits for speed lock, enforces the spin-up timeout with
//             bounded restarts, filters lock drop-out and qualifies ranging.
//  Options  : MOTOR_AUTO_RETRY_EN - enables automatic restart attempts.
//             Undefined: timeout or lock loss goes straight to FAULT.
//  Revision : 1.0 - initial release
// ============================================================================
module motor_run_sequencer #(
    parameter logic [31:0] SPINUP_TIMEOUT = 32'd1_500_000_000,
    parameter logic [31:0] RESTART_GAP    = 32'd50_000_000,
    parameter logic [23:0] LOSS_FILTER    = 24'd5_000_000,
    parameter logic [2:0]  MAX_RETRY      = 3'd3
) (
    input  logic       i_clk_50m,
    input  logic       i_rst_n,
    input  logic       i_start_req,
    input  logic       i_stop_req,
    input  logic       i_cal_req,
    input  logic [2:0] i_freq_req,
    input  logic       i_motor_state,
    output logic [2:0] o_freq_mode,
    output logic       o_measure_mode,
    output logic       o_cal_mode,
    output logic       o_scan_ready,
    output logic       o_fault,
    output logic [2:0] o_retry_cnt,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SPINUP = 3'd1,
        S_RUN    = 3'd2,
        S_GAP    = 3'd3,
        S_CAL    = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] cyc_cnt;
    logic [23:0] loss_cnt;
    logic [23:0] loss_cnt_nx;
    logic [23:0] loss_inc;
    logic [2:0]  retry_nx;
    logic        fault_nx;
    logic        gap_fault;
    logic        gap_fault_nx;
    logic [2:0]  freq_req_mapped;
    logic        timeout_hit;
    logic        gap_done;
    logic        loss_hit;
    logic        retry_room;

    // Code 7 is not a valid speed; it falls back to the slowest setting.
    assign freq_req_mapped = (i_freq_req == 3'd7) ? 3'd0 : i_freq_req;

    assign timeout_hit = (cyc_cnt == SPINUP_TIMEOUT - 32'd1);
    assign gap_done    = (cyc_cnt == RESTART_GAP - 32'd1);
    assign loss_inc    = (loss_cnt == 24'hFF_FFFF) ? loss_cnt : loss_cnt + 24'd1;
    assign loss_hit    = (state == S_RUN) && !i_motor_state && (loss_inc == LOSS_FILTER);

`ifdef MOTOR_AUTO_RETRY_EN
    assign retry_room = (o_retry_cnt < MAX_RETRY);
`else
    // Retries disabled in this build: the budget is always exhausted.
    assign retry_room = 1'b0 & (o_retry_cnt < MAX_RETRY);
`endif

    // Next-state and next-bookkeeping: stop > cal > start > internal events.
    always_comb begin
        state_nx     = state;
        retry_nx     = o_retry_cnt;
        fault_nx     = o_fault;
        gap_fault_nx = gap_fault;
        loss_cnt_nx  = 24'd0;
        if (i_stop_req) begin
            state_nx = S_IDLE;
        end else if (i_cal_req) begin
            state_nx = S_CAL;
        end else if (i_start_req && (state != S_SPINUP) && (state != S_RUN)) begin
            state_nx = S_SPINUP;
            retry_nx = 3'd0;
            fault_nx = 1'b0;
        end else begin
            case (state)
                S_SPINUP: begin
                    if (i_motor_state) begin
                        state_nx = S_RUN;
                    end else if (timeout_hit) begin
                        if (retry_room) begin
                            state_nx     = S_GAP;
                            retry_nx     = o_retry_cnt + 3'd1;
                            gap_fault_nx = 1'b0;
                        end else begin
                            state_nx = S_FAULT;
                        end
                    end
                end
                S_RUN: begin
                    if (loss_hit) begin
`ifdef MOTOR_AUTO_RETRY_EN
                        // Out of retries: still hold the drive off for one
                        // gap, then give up at the end of it.
                        state_nx = S_GAP;
                        if (retry_room) begin
                            retry_nx     = o_retry_cnt + 3'd1;
                            gap_fault_nx = 1'b0;
                        end else begin
                            gap_fault_nx = 1'b1;
                        end
`else
                        state_nx = S_FAULT;
`endif
                    end else if (freq_req_mapped != o_freq_mode) begin
                        state_nx     = S_GAP;
                        gap_fault_nx = 1'b0;
                    end
                end
                S_GAP: begin
                    if (gap_done) begin
                        state_nx = gap_fault ? S_FAULT : S_SPINUP;
                    end
                end
                S_CAL:   state_nx = S_IDLE;
                S_FAULT: state_nx = S_FAULT;
                S_IDLE:  state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
        if (state_nx == S_FAULT) begin
            fault_nx = 1'b1;
        end
        if ((state == S_RUN) && (state_nx == S_RUN) && !i_motor_state) begin
            loss_cnt_nx = loss_inc;
        end
    end

    // State register, counters and registered drive outputs.
    always_ff @(posedge i_clk_50m) begin
        if (!i_rst_n) begin
            state          <= S_IDLE;
            cyc_cnt        <= 32'd0;
            loss_cnt       <= 24'd0;
            gap_fault      <= 1'b0;
            o_freq_mode    <= 3'd0;
            o_measure_mode <= 1'b0;
            o_cal_mode     <= 1'b0;
            o_scan_ready   <= 1'b0;
            o_fault        <= 1'b0;
            o_retry_cnt    <= 3'd0;
            o_state        <= 3'd0;
        end else begin
            state       <= state_nx;
            loss_cnt    <= loss_cnt_nx;
            gap_fault   <= gap_fault_nx;
            o_fault     <= fault_nx;
            o_retry_cnt <= retry_nx;
            if (state_nx != state) begin
                cyc_cnt <= 32'd0;
            end else if (cyc_cnt != 32'hFFFF_FFFF) begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end
            if ((state_nx == S_SPINUP) && (state != S_SPINUP)) begin
                o_freq_mode <= freq_req_mapped;
            end
            o_measure_mode <= (state_nx == S_SPINUP) || (state_nx == S_RUN) ||
                              (state_nx == S_CAL);
            o_cal_mode     <= (state_nx == S_CAL);
            o_scan_ready   <= (state_nx == S_RUN);
            o_state        <= state_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_motor_run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_motor_run_sequencer
//  Purpose  : Directed and randomized checks of motor_run_sequencer against
//             a cycle-level behavioural model of the sequencing rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_motor_run_sequencer;

    localparam int T  = 1000;
    localparam int G  = 20;
    localparam int LF = 50;
    localparam int MR = 2;
`ifdef MOTOR_AUTO_RETRY_EN
    localparam int MR_EFF = MR;
`else
    localparam int MR_EFF = 0;
`endif

    localparam int IDLE = 0, SPINUP = 1, RUN = 2, GAP = 3, CAL = 4, FAULT = 5;

    logic       clk = 1'b0;
    logic       rst_n, start, stop, cal, lock;
    logic [2:0] freq;
    logic [2:0] freq_mode, retry_cnt, state_code;
    logic       measure, cal_mode, scan_ready, fault;

    int tests = 0;
    int fails = 0;

    // Model: state name, time spent in state, consecutive unlocked RUN cycles.
    int m_state, m_time, m_unlocked, m_freq, m_retry;
    bit m_fault, m_give_up;

    motor_run_sequencer #(
        .SPINUP_TIMEOUT(32'(T)),
        .RESTART_GAP   (32'(G)),
        .LOSS_FILTER   (24'(LF)),
        .MAX_RETRY     (3'(MR))
    ) dut (
        .i_clk_50m     (clk),
        .i_rst_n       (rst_n),
        .i_start_req   (start),
        .i_stop_req    (stop),
        .i_cal_req     (cal),
        .i_freq_req    (freq),
        .i_motor_state (lock),
        .o_freq_mode   (freq_mode),
        .o_measure_mode(measure),
        .o_cal_mode    (cal_mode),
        .o_scan_ready  (scan_ready),
        .o_fault       (fault),
        .o_retry_cnt   (retry_cnt),
        .o_state       (state_code)
    );

    always #10 clk = ~clk;

    function automatic int speed_of(input logic [2:0] code);
        return (code == 3'd7) ? 0 : int'(code);
    endfunction

    task automatic model_reset();
        m_state = IDLE; m_time = 0; m_unlocked = 0; m_freq = 0;
        m_retry = 0; m_fault = 0; m_give_up = 0;
    endtask

    // One clock of the sequencing rules, written from the request priority list.
    task automatic model_step();
        int nxt;
        nxt = m_state;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (stop) nxt = IDLE;
        else if (cal) nxt = CAL;
        else if (start && m_state != SPINUP && m_state != RUN) begin
            nxt = SPINUP; m_retry = 0; m_fault = 0;
        end else if (m_state == SPINUP) begin
            if (lock) nxt = RUN;
            else if (m_time == T - 1) begin
                if (m_retry < MR_EFF) begin nxt = GAP; m_retry++; m_give_up = 0; end
                else nxt = FAULT;
            end
        end else if (m_state == RUN) begin
            if (!lock && m_unlocked + 1 == LF) begin
                if (MR_EFF == 0) nxt = FAULT;
                else begin
                    nxt = GAP;
                    if (m_retry < MR_EFF) begin m_retry++; m_give_up = 0; end
                    else m_give_up = 1;
                end
            end else if (speed_of(freq) != m_freq) begin
                nxt = GAP; m_give_up = 0;
            end
        end else if (m_state == GAP) begin
            if (m_time == G - 1) nxt = m_give_up ? FAULT : SPINUP;
        end else if (m_state == CAL) begin
            nxt = IDLE;
        end
        m_unlocked = (m_state == RUN && nxt == RUN && !lock) ? m_unlocked + 1 : 0;
        if (nxt == SPINUP && m_state != SPINUP) m_freq = speed_of(freq);
        if (nxt == FAULT) m_fault = 1;
        m_time = (nxt != m_state) ? 0 : m_time + 1;
        m_state = nxt;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("state",     32'(state_code), 32'(m_state));
        chk("measure",   32'(measure),    32'(m_state == SPINUP || m_state == RUN || m_state == CAL));
        chk("cal_mode",  32'(cal_mode),   32'(m_state == CAL));
        chk("ready",     32'(scan_ready), 32'(m_state == RUN));
        chk("fault",     32'(fault),      32'(m_fault));
        chk("retry",     32'(retry_cnt),  32'(m_retry));
        chk("freq_mode", 32'(freq_mode),  32'(m_freq));
    endtask

    task automatic cycle(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_step();
            #1;
            check_model();
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; cycle(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; cycle(); stop = 1'b0;
    endtask

    int saved_retry;

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; cal = 1'b0; lock = 1'b0; freq = 3'd0;
        model_reset();
        #1;

        // Reset values
        cycle(3);
        chk("rst_state", 32'(state_code), 0);
        chk("rst_measure", 32'(measure), 0);
        chk("rst_fault", 32'(fault), 0);
        rst_n = 1'b1;
        cycle(2);

        // Lock after 200 cycles of spin-up
        freq = 3'd2;
        pulse_start();
        chk("spin_state", 32'(state_code), SPINUP);
        cycle(199);
        chk("spin_ready_low", 32'(scan_ready), 0);
        lock = 1'b1;
        cycle();
        chk("lock_state", 32'(state_code), RUN);
        chk("lock_ready", 32'(scan_ready), 1);
        chk("lock_freq", 32'(freq_mode), 2);

        // Lock loss filter: 49 low cycles survive, 50 do not
        lock = 1'b0; cycle(LF - 1);
        lock = 1'b1; cycle();
        chk("loss49_state", 32'(state_code), RUN);
        lock = 1'b0; cycle(LF);
        chk("loss50_state", 32'(state_code), (MR_EFF > 0) ? GAP : FAULT);
        chk("loss50_ready", 32'(scan_ready), 0);
        chk("loss50_retry", 32'(retry_cnt), (MR_EFF > 0) ? 1 : 0);
        pulse_stop();
        chk("stop_fault_held", 32'(fault), (MR_EFF > 0) ? 0 : 1);

        // Speed change in RUN
        freq = 3'd0; lock = 1'b0;
        pulse_start();
        lock = 1'b1; cycle(3);
        saved_retry = int'(retry_cnt);
        lock = 1'b0; freq = 3'd3;
        cycle();
        chk("spd_gap", 32'(state_code), GAP);
        chk("spd_measure", 32'(measure), 0);
        cycle(G - 1);
        chk("spd_gap_end", 32'(state_code), GAP);
        cycle();
        chk("spd_spinup", 32'(state_code), SPINUP);
        chk("spd_freq", 32'(freq_mode), 3);
        chk("spd_retry", 32'(retry_cnt), 32'(saved_retry));

        // Spin-up timeout and restarts
        pulse_stop();
        pulse_start();
        cycle(T - 1);
        chk("to_spin_last", 32'(state_code), SPINUP);
        cycle();
        chk("to_first", 32'(state_code), (MR_EFF > 0) ? GAP : FAULT);
        chk("to_first_retry", 32'(retry_cnt), (MR_EFF > 0) ? 1 : 0);
        cycle(MR_EFF * (T + G) + 5);
        chk("to_fault", 32'(fault), 1);
        chk("to_retry", 32'(retry_cnt), MR_EFF);
        chk("to_measure", 32'(measure), 0);
        chk("to_state", 32'(state_code), FAULT);

        // Repeated lock loss exhausts retries
        pulse_start();
        for (int a = 0; a <= MR; a++) begin
            lock = 1'b1; cycle(2);
            lock = 1'b0; cycle(LF + G);
        end
        chk("ll_state", 32'(state_code), FAULT);
        chk("ll_fault", 32'(fault), 1);
        chk("ll_retry", 32'(retry_cnt), MR_EFF);

        // Stop, cal and start together in RUN
        pulse_start();
        lock = 1'b1; cycle(2);
        stop = 1'b1; cal = 1'b1; start = 1'b1;
        cycle();
        stop = 1'b0; cal = 1'b0; start = 1'b0;
        chk("prio_state", 32'(state_code), IDLE);
        chk("prio_measure", 32'(measure), 0);
        chk("prio_cal", 32'(cal_mode), 0);
        chk("prio_ready", 32'(scan_ready), 0);

        // Reset during GAP
        pulse_start();
        cycle(2);
        freq = 3'd5; cycle(4);
        chk("gap_before_rst", 32'(state_code), GAP);
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        chk("rst_gap_state", 32'(state_code), 0);
        chk("rst_gap_freq", 32'(freq_mode), 0);
        chk("rst_gap_retry", 32'(retry_cnt), 0);

        // Calibration
        cal = 1'b1; cycle(3);
        chk("cal_state", 32'(state_code), CAL);
        chk("cal_mode", 32'(cal_mode), 1);
        cal = 1'b0; cycle();
        chk("cal_exit", 32'(state_code), IDLE);

        // Randomized traffic against the model
        for (int i = 0; i < 6000; i++) begin
            start = ($urandom_range(0, 39) == 0);
            stop  = ($urandom_range(0, 249) == 0);
            rst_n = ($urandom_range(0, 1499) != 0);
            if ($urandom_range(0, 299) == 0) cal = ~cal;
            if ($urandom_range(0, 149) == 0) freq = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 29) == 0) lock = ~lock;
            cycle();
        end
        start = 1'b0; stop = 1'b0; cal = 1'b0; rst_n = 1'b1;
        cycle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
